// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port among NUM_REQ
// valid/ready producers, with bounded bursts per grant.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   grant_id_nxt;
  logic [ID_W-1:0]   last_id, last_id_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;

  logic              hi_found, lo_found;
  logic [ID_W-1:0]   hi_id, lo_id, pick_id;
  logic              cur_valid;
  logic [DATA_WIDTH-1:0] cur_data;

  assign grant_valid = (state == GRANT);

  // Round-robin pick: lowest valid index above last_id, else lowest overall
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (ID_W'(i) > last_id) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_id    = ID_W'(i);
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_id    = ID_W'(i);
        end
      end
    end
    pick_id = hi_found ? hi_id : lo_id;
  end

  // Select valid and data of the current grantee
  always_comb begin
    cur_valid = 1'b0;
    cur_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id) begin
        cur_valid = req_valid[i];
        cur_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state, burst counting and write-port outputs
  always_comb begin
    state_nxt    = state;
    grant_id_nxt = grant_id;
    last_id_nxt  = last_id;
    beat_cnt_nxt = beat_cnt;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_din     = '0;
    case (state)
      IDLE: begin
        if (hi_found || lo_found) begin
          grant_id_nxt = pick_id;
          beat_cnt_nxt = '0;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (ID_W'(i) == grant_id) begin
            req_ready[i] = ~fifo_full;
          end
        end
        fifo_wr_en = cur_valid & ~fifo_full;
        fifo_din   = cur_data;
        if (!cur_valid) begin
          // Requester released the grant early
          state_nxt    = IDLE;
          last_id_nxt  = grant_id;
          grant_id_nxt = '0;
        end else if (!fifo_full) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
          if (beat_cnt == CNT_W'(BURST_LEN - 1)) begin
            state_nxt    = IDLE;
            last_id_nxt  = grant_id;
            grant_id_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; last_id resets to the top index so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      last_id  <= ID_W'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_id_nxt;
      last_id  <= last_id_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random checks of fifo_wr_arbiter with NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=4.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic        grant_valid;
  logic [1:0]  grant_id;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Producers: requester i sends i*16 + (beats accepted so far), up to lim[i] beats
  logic [3:0] en;
  int cnt[4] = '{default: 0};
  int lim[4] = '{default: 0};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_valid[i]         = en[i] && (cnt[i] < lim[i]);
      req_data[i*8 +: 8]   = 8'(i * 16 + cnt[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) cnt[i] <= cnt[i] + 1;
  end

  // Write-side scoreboard: each write must be the next beat of the granted stream
  int cyc = 0;
  int wr_total = 0;
  int sb_err = 0;
  int wr_cnt[4] = '{default: 0};
  int wd[$];
  int wt[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_wr_en) begin
      if (fifo_din !== 8'(int'(grant_id) * 16 + wr_cnt[grant_id])) sb_err <= sb_err + 1;
      wr_cnt[grant_id] <= wr_cnt[grant_id] + 1;
      wr_total <= wr_total + 1;
      wd.push_back(int'(fifo_din));
      wt.push_back(cyc);
    end
  end

  // Grant log, idle-write watch and fairness tracking
  logic prev_gv = 1'b0;
  int   bad_wr = 0;
  int   gq[$];
  int   gstart[$];
  int   waitc[4] = '{default: 0};
  int   max_wait = 0;
  bit   fair_on = 1'b0;

  always @(negedge clk) begin
    prev_gv <= grant_valid;
    if (!grant_valid && fifo_wr_en) bad_wr <= bad_wr + 1;
    if (grant_valid && !prev_gv) begin
      gq.push_back(int'(grant_id));
      gstart.push_back(wr_total);
    end
    for (int i = 0; i < 4; i++) begin
      if (!req_valid[i]) waitc[i] <= 0;
      else if (grant_valid && !prev_gv) begin
        if (int'(grant_id) == i) waitc[i] <= 0;
        else waitc[i] <= waitc[i] + 1;
      end
      if (fair_on && waitc[i] > max_wait) max_wait <= waitc[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    en = '0;
    tick(1);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick(1);
  endtask

  int gb, wb, c0, wt_rst;

  initial begin
    rst_n     = 1'b0;
    en        = '0;
    fifo_full = 1'b0;

    // Reset values
    #12;
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_grant_id",    32'(grant_id),    32'd0);
    check("rst_wr_en",       32'(fifo_wr_en),  32'd0);
    check("rst_ready",       32'(req_ready),   32'd0);
    check("rst_din",         32'(fifo_din),    32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Requester 2 alone, 8 beats 0x20..0x27
    wb = wd.size();
    lim[2] = 8;
    en = 4'b0100;
    check("t1_pre_grant", 32'(grant_valid), 32'd0);
    tick(1);
    check("t1_grant_valid", 32'(grant_valid), 32'd1);
    check("t1_grant_id",    32'(grant_id),    32'd2);
    check("t1_ready",       32'(req_ready),   32'h4);
    check("t1_wr_en",       32'(fifo_wr_en),  32'd1);
    check("t1_din",         32'(fifo_din),    32'h20);
    tick(12);
    check("t1_nwrites", 32'(wd.size() - wb), 32'd8);
    for (int k = 0; k < 8; k++)
      if (wb + k < wd.size()) check($sformatf("t1_data%0d", k), 32'(wd[wb+k]), 32'h20 + 32'(k));
    if (wb + 4 < wt.size()) begin
      check("t1_burst_span", 32'(wt[wb+3] - wt[wb]),   32'd3);
      check("t1_bubble",     32'(wt[wb+4] - wt[wb+3]), 32'd2);
    end
    check("t1_idle_end", 32'(grant_valid), 32'd0);

    // All four continuously valid
    pulse_reset();
    for (int i = 0; i < 4; i++) lim[i] = cnt[i] + 100;
    gb = gq.size();
    en = 4'hF;
    tick(26);
    en = '0;
    tick(4);
    check("t2_ngrants_ge5", 32'(gq.size() - gb >= 5), 32'd1);
    if (gq.size() - gb >= 5) begin
      for (int k = 0; k < 5; k++)
        check($sformatf("t2_order%0d", k), 32'(gq[gb+k]), 32'(k % 4));
      for (int k = 0; k < 4; k++)
        check($sformatf("t2_beats%0d", k), 32'(gstart[gb+k+1] - gstart[gb+k]), 32'd4);
    end
    check("t2_no_idle_write", 32'(bad_wr), 32'd0);

    // Requester 1 drops after 2 beats while requester 3 waits
    pulse_reset();
    lim[1] = cnt[1] + 2;
    lim[3] = cnt[3] + 4;
    gb = gq.size();
    en = 4'b1010;
    tick(15);
    check("t3_ngrants", 32'(gq.size() - gb), 32'd2);
    if (gq.size() - gb == 2) begin
      check("t3_first",   32'(gq[gb]),   32'd1);
      check("t3_second",  32'(gq[gb+1]), 32'd3);
      check("t3_beats1",  32'(gstart[gb+1] - gstart[gb]), 32'd2);
      check("t3_beats3",  32'(wr_total - gstart[gb+1]),   32'd4);
    end
    en = '0;

    // fifo_full held for 5 cycles mid-burst on requester 0
    pulse_reset();
    c0 = cnt[0];
    lim[0] = cnt[0] + 4;
    gb = gq.size();
    wb = wd.size();
    en = 4'b0001;
    tick(3);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t4_stall_ready%0d", k), 32'(req_ready),   32'd0);
      check($sformatf("t4_stall_wr%0d", k),    32'(fifo_wr_en),  32'd0);
      check($sformatf("t4_stall_gv%0d", k),    32'(grant_valid), 32'd1);
      tick(1);
    end
    fifo_full = 1'b0;
    #1;
    check("t4_resume_wr", 32'(fifo_wr_en), 32'd1);
    tick(6);
    check("t4_ngrants", 32'(gq.size() - gb), 32'd1);
    check("t4_nwrites", 32'(wd.size() - wb), 32'd4);
    for (int k = 0; k < 4; k++)
      if (wb + k < wd.size()) check($sformatf("t4_data%0d", k), 32'(wd[wb+k]), 32'(8'(c0 + k)));
    en = '0;

    // Asynchronous reset during beat 2 of a grant to requester 3
    pulse_reset();
    lim[3] = cnt[3] + 100;
    lim[0] = cnt[0] + 100;
    wb = wr_total;
    en = 4'b1000;
    tick(1);
    check("t5_grant_id", 32'(grant_id), 32'd3);
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    wt_rst = wr_total;
    check("t5_async_gv",    32'(grant_valid), 32'd0);
    check("t5_async_id",    32'(grant_id),    32'd0);
    check("t5_async_wr",    32'(fifo_wr_en),  32'd0);
    check("t5_async_ready", 32'(req_ready),   32'd0);
    check("t5_async_din",   32'(fifo_din),    32'd0);
    check("t5_beats_before", 32'(wt_rst - wb), 32'd2);
    en = 4'b1001;
    #1 rst_n = 1'b1;
    tick(1);
    check("t5_after_gv", 32'(grant_valid), 32'd1);
    check("t5_after_id", 32'(grant_id),    32'd0);
    en = '0;
    tick(4);

    // Random valid/full traffic
    pulse_reset();
    for (int i = 0; i < 4; i++) lim[i] = cnt[i] + 100000;
    fair_on = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!en[i]) en[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 15) == 0) en[i] = 1'b0;
      end
      tick(1);
    end
    en = '0;
    fifo_full = 1'b0;
    tick(10);
    fair_on = 1'b0;
    check("sb_data_errors", 32'(sb_err), 32'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("sb_count%0d", i), 32'(wr_cnt[i]), 32'(cnt[i]));
    check("fair_max_wait_le3", 32'(max_wait <= 3), 32'd1);
    check("no_idle_write_all", 32'(bad_wr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that lets NUM_REQ independent producers share the single write port of one `sync_fifo` instance. Each producer presents data on a valid/ready handshake. The arbiter grants one producer at a time, holds the grant for a bounded burst, and drives the FIFO's `wr_en`/`din` while respecting `full`. It sits directly in front of `sync_fifo`; the read side of the FIFO is untouched.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..16).
- `DATA_WIDTH`, default 8: data width; must equal the FIFO data width.
- `BURST_LEN`, default 4: maximum beats accepted per grant (1..256).
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: per-requester data valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ: per-requester accept; a beat transfers when valid and ready are both high on a rising edge.
- `fifo_full`  in  1: FIFO `full` flag.
- `fifo_wr_en`  out  1: connects to FIFO `wr_en`.
- `fifo_din`  out  DATA_WIDTH: connects to FIFO `din`.
- `grant_valid`  out  1: high while in GRANT state.
- `grant_id`  out  clog2(NUM_REQ): index of the current grantee; 0 when not granting.

## Operation
- FSM states are IDLE and GRANT.
- **IDLE:** if any `req_valid` bit is high, select the first set bit searching upward from `last_id+1` modulo NUM_REQ. Register it as `grant_id`, clear `beat_cnt`, and go to GRANT. Otherwise stay in IDLE.
- **GRANT:**
  - `req_ready[grant_id] = ~fifo_full`; all other ready bits are 0.
  - `fifo_wr_en = req_valid[grant_id] & ~fifo_full`.
  - `fifo_din = req_data` slice of `grant_id`.
  - On every accepted beat, `beat_cnt` increments.
- **GRANT exit:**
  - An accepted beat with `beat_cnt == BURST_LEN-1` goes to IDLE, burst complete.
  - `req_valid[grant_id]` low goes to IDLE, releasing the grant; no beat is accepted in that cycle.
  - Otherwise stay in GRANT. This includes `fifo_full` high: the grant is held and no beat is counted.
- On leaving GRANT, `last_id` is set to `grant_id`.
- Outside GRANT, `fifo_wr_en` is 0 and all `req_ready` bits are 0.
- `fifo_din` is the granted slice in GRANT and 0 otherwise, so no X reaches the FIFO.
- `beat_cnt` is clog2(BURST_LEN)+1 bits wide and never wraps; it is cleared on grant entry.
- Requesters must hold `req_data` stable while valid and not ready.
- Requesters may drop `req_valid` at any time. Dropping valid is the only way to end a burst early.

## Timing
- Reset values, applied asynchronously on `rst_n` low:
  - state IDLE, `grant_valid` 0, `grant_id` 0, `beat_cnt` 0.
  - `last_id` = NUM_REQ-1, so requester 0 has first priority after reset.
  - `fifo_wr_en` 0, `req_ready` all 0, `fifo_din` 0.
- Arbitration latency: a valid seen in IDLE at edge N gives `grant_valid` high after edge N, and the first beat can be written at edge N+1.
- Each grant costs one idle bubble cycle. With one requester continuously valid, peak throughput is BURST_LEN beats per BURST_LEN+1 cycles.
- `req_ready` and `fifo_wr_en` are combinational from state, `req_valid` and `fifo_full`. There is no combinational path from `req_data` to the control outputs.
- `fifo_full` asserting mid-burst stalls the burst the same cycle; it resumes the cycle `fifo_full` drops.
- A requester that asserts valid in the same cycle another is granted waits for the current grant to finish. The worst-case wait is NUM_REQ-1 grants, each at most BURST_LEN+1 cycles plus full stalls.
- `rst_n` asserted mid-burst aborts the burst immediately. `fifo_wr_en` drops asynchronously and no partial beat is counted. After release, arbitration restarts from requester 0.
- `sync_fifo` on its own reset must be released with or after `rst_n`.

## Test plan
(NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=4)
- Reset then requester 2 alone, valid with data 0x20..0x27 -> grant_id=2 one cycle after valid; FIFO receives 0x20..0x23, one bubble, then 0x24..0x27.
- All four requesters continuously valid -> grant order 0,1,2,3,0. Each grant writes exactly 4 beats and `fifo_wr_en` is never high in IDLE cycles.
- Requester 1 drops valid after 2 beats while requester 3 is valid -> grant released, 2 beats written, next grant_id=3.
- `fifo_full` forced high for 5 cycles mid-burst on requester 0 -> `req_ready`/`fifo_wr_en` low for those cycles, grant held. The burst completes with 4 total beats and no duplicated or lost data.
- `rst_n` pulsed low during beat 2 of a grant to requester 3 -> outputs reach reset values without waiting for `clk`. The next grant goes to requester 0 even though requester 3 is still valid.
- Scoreboard check over 1000 random valid/full cycles -> the FIFO write stream equals the per-requester input streams interleaved by grant. No requester waits more than 3 grants.
